// File: rtl/ball_move_sequencer.sv
// Tick-paced ball mover: decodes tilt into per-axis steps and commits each step only after the map ROM confirms the cell is not a wall.
// Optional build macro MAP_TIMEOUT_EN adds a map_ack timeout and the sticky map_timeout output.
module ball_move_sequencer #(
    parameter int         CLK_FREQUENCY_HZ       = 100000000,
    parameter int         UPDATE_FREQUENCY_HZ    = 5,
    parameter int         CNTR_WIDTH             = 32,
    parameter int         SIMULATE               = 0,
    parameter int         SIMULATE_FREQUENCY_CNT = 5,
    parameter int         X_MAX                  = 127,
    parameter int         Y_MAX                  = 127,
    parameter int         X_START                = 1,
    parameter int         Y_START                = 1,
    parameter int         DEADZONE               = 16,
    parameter logic [1:0] WALL_CODE              = 2'd2,
    parameter int         TIMEOUT_CYCLES         = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [8:0] accelX_IN,
    input  logic signed [8:0] accelY_IN,
    output logic              map_req,
    output logic [7:0]        map_x,
    output logic [7:0]        map_y,
    input  logic              map_ack,
    input  logic [1:0]        map_value,
    output logic [7:0]        x_out,
    output logic [7:0]        y_out,
    output logic              busy,
    output logic              move_done,
    output logic [1:0]        blocked,
    output logic              tick_overrun
`ifdef MAP_TIMEOUT_EN
    ,
    output logic              map_timeout
`endif
);

    localparam logic [CNTR_WIDTH-1:0] TOP_CNT = (SIMULATE != 0)
        ? CNTR_WIDTH'(SIMULATE_FREQUENCY_CNT)
        : CNTR_WIDTH'(CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ - 1);
    localparam logic [7:0]        X_LIM  = 8'(X_MAX);
    localparam logic [7:0]        Y_LIM  = 8'(Y_MAX);
    localparam logic [7:0]        X_INIT = 8'(X_START);
    localparam logic [7:0]        Y_INIT = 8'(Y_START);
    localparam logic signed [9:0] DZ     = 10'(DEADZONE);

    typedef enum logic [2:0] {
        IDLE,
        CHECK_X,
        WAIT_X,
        CHECK_Y,
        WAIT_Y,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNTR_WIDTH-1:0] div_cnt;
    logic                  tick;
    logic signed [1:0]     dx;
    logic signed [1:0]     dy;
    logic                  x_skip;
    logic                  y_skip;
    logic                  wait_state;
    logic                  resolve;
    logic                  wall_hit;

    // Tilt beyond the deadzone in either direction yields a unit step.
    function automatic logic signed [1:0] tilt_step(input logic signed [8:0] tilt);
        logic signed [9:0] t;
        t = {tilt[8], tilt};
        if (t > DZ)
            return 2'sb01;
        else if (t < -DZ)
            return 2'sb11;
        else
            return 2'sb00;
    endfunction

    function automatic logic [7:0] step_coord(input logic [7:0] pos, input logic signed [1:0] d);
        return d[1] ? pos - 8'd1 : pos + 8'd1;
    endfunction

    // An axis is skipped when it has no step or the step would leave the board.
    function automatic logic skip_axis(input logic [7:0] pos, input logic signed [1:0] d,
                                       input logic [7:0] lim);
        return (d == 2'sb00) || (d[1] && pos == 8'd0) || (!d[1] && pos == lim);
    endfunction

    assign tick       = (div_cnt == TOP_CNT);
    assign x_skip     = skip_axis(x_out, dx, X_LIM);
    assign y_skip     = skip_axis(y_out, dy, Y_LIM);
    assign wait_state = (state == WAIT_X) || (state == WAIT_Y);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

`ifdef MAP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            timeout_hit;

    assign timeout_hit = wait_state && !map_ack && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign resolve     = wait_state && (map_ack || timeout_hit);
    // A timed-out query is treated exactly like a wall.
    assign wall_hit    = !map_ack || (map_value == WALL_CODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            map_timeout <= 1'b0;
        end else begin
            if (wait_state && !resolve)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout_hit)
                map_timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign resolve            = wait_state && map_ack;
    assign wall_hit           = (map_value == WALL_CODE);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        move_done  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (tick)
                    state_next = CHECK_X;
            end
            CHECK_X: state_next = x_skip ? CHECK_Y : WAIT_X;
            WAIT_X: begin
                if (resolve)
                    state_next = CHECK_Y;
            end
            CHECK_Y: state_next = y_skip ? DONE : WAIT_Y;
            WAIT_Y: begin
                if (resolve)
                    state_next = DONE;
            end
            DONE: begin
                move_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // X is resolved before Y, so the Y query already sees the committed x_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_out        <= X_INIT;
            y_out        <= Y_INIT;
            dx           <= 2'sb00;
            dy           <= 2'sb00;
            map_req      <= 1'b0;
            map_x        <= 8'd0;
            map_y        <= 8'd0;
            blocked      <= 2'b00;
            tick_overrun <= 1'b0;
        end else begin
            blocked <= 2'b00;
            if (tick && state != IDLE)
                tick_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        dx <= tilt_step(accelX_IN);
                        dy <= tilt_step(accelY_IN);
                    end
                end
                CHECK_X: begin
                    if (!x_skip) begin
                        map_x   <= step_coord(x_out, dx);
                        map_y   <= y_out;
                        map_req <= 1'b1;
                    end
                end
                WAIT_X: begin
                    if (resolve) begin
                        map_req <= 1'b0;
                        if (wall_hit)
                            blocked[0] <= 1'b1;
                        else
                            x_out <= map_x;
                    end
                end
                CHECK_Y: begin
                    if (!y_skip) begin
                        map_x   <= x_out;
                        map_y   <= step_coord(y_out, dy);
                        map_req <= 1'b1;
                    end
                end
                WAIT_Y: begin
                    if (resolve) begin
                        map_req <= 1'b0;
                        if (wall_hit)
                            blocked[1] <= 1'b1;
                        else
                            y_out <= map_y;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ball_move_sequencer.md
Name: ball_move_sequencer

Overview:
- Tick-driven controller that owns the ball position register and schedules every move.
- On each update tick it converts accelerometer tilt into a per-axis step, then queries the map ROM arbiter for each proposed cell. It commits the step only when the cell is not a wall.
- Sits between the accelerometer interface, the shared map-ROM read port and the VGA ball renderer (x_out/y_out).

Parameters:
CLK_FREQUENCY_HZ, 100000000, system clock frequency
UPDATE_FREQUENCY_HZ, 5, move-attempt rate
CNTR_WIDTH, 32, tick divider counter width
SIMULATE, 0, 1 = use SIMULATE_FREQUENCY_CNT as divider terminal count
SIMULATE_FREQUENCY_CNT, 5, divider terminal count in simulation
X_MAX, 127, largest legal x coordinate
Y_MAX, 127, largest legal y coordinate
X_START, 1, x position after reset
Y_START, 1, y position after reset
DEADZONE, 16, tilt magnitude at or below which an axis does not move
WALL_CODE, 2, map_value encoding that blocks movement
TIMEOUT_CYCLES, 64, map ack timeout (optional feature only)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
accelX_IN  input  9  signed two's-complement X tilt
accelY_IN  input  9  signed two's-complement Y tilt
map_req  output  1  map read request
map_x  output  8  map query x
map_y  output  8  map query y
map_ack  input  1  map read done; map_value valid in the same cycle
map_value  input  2  cell code at (map_x, map_y)
x_out  output  8  committed ball x
y_out  output  8  committed ball y
busy  output  1  high in any state other than IDLE
move_done  output  1  1-cycle pulse at the end of each move attempt
blocked  output  2  1-cycle pulse: bit0 = X step rejected by wall, bit1 = Y step rejected by wall
tick_overrun  output  1  sticky flag: a tick arrived while busy

Behaviour:
- Reset: reset low clears all state asynchronously.
  - x_out=X_START, y_out=Y_START.
  - map_req, move_done, blocked, tick_overrun, busy = 0.
  - map_x=map_y=0, divider=0, state=IDLE.
  - Assertion mid-handshake drops map_req immediately. The pending query is abandoned and never committed.
- Tick: internal 1-cycle pulse when the divider reaches top_cnt = SIMULATE ? SIMULATE_FREQUENCY_CNT : CLK_FREQUENCY_HZ/UPDATE_FREQUENCY_HZ-1; the divider then wraps to 0.
- Direction decode, per axis, signed 9-bit:
  - value > +DEADZONE gives step +1.
  - value < -DEADZONE gives step -1.
  - otherwise step 0.
- FSM states: IDLE, CHECK_X, WAIT_X, CHECK_Y, WAIT_Y, DONE.
- IDLE: on tick, latch dx and dy from the current accel inputs and go to CHECK_X. Later accel changes are ignored until the next tick.
- CHECK_X:
  - Skip to CHECK_Y, with no request, when dx=0, or dx=-1 with x_out=0, or dx=+1 with x_out=X_MAX.
  - Otherwise register map_x=x_out+dx, map_y=y_out, map_req=1, and go to WAIT_X.
- WAIT_X:
  - map_req and the address are held stable until map_ack=1 is sampled.
  - On ack: if map_value==WALL_CODE, pulse blocked[0]; else x_out<=map_x. Clear map_req on the next edge and go to CHECK_Y.
- CHECK_Y / WAIT_Y: identical to X, using the already-updated x_out, map_y=y_out+dy and blocked[1].
- DONE: pulse move_done for one cycle, then return to IDLE.
- Latency: a tick to the first map_req takes 2 cycles. A zero-wait map (ack in the first WAIT cycle) completes a two-axis move in 6 cycles.
- Diagonal moves are resolved as X then Y, each checked separately. The ball can slide along a wall.
- Boundaries:
  - x_out/y_out never wrap.
  - A tick while busy is dropped and sets tick_overrun, which is cleared only by reset.
  - map_ack outside a WAIT state is ignored.

Optional Feature:
- Macro: MAP_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_X/WAIT_Y.
  - If TIMEOUT_CYCLES elapse without map_ack, the step is treated as blocked: the blocked bit pulses, map_req drops, and the FSM advances.
  - Adds output map_timeout, a sticky flag cleared only by reset.
- Undefined: WAIT states hold indefinitely, no timeout logic or port.

Test Plan:
- Reset with X_START=1,Y_START=1, SIMULATE=1 -> x_out=1, y_out=1, map_req=0. After release the first tick arrives at cycle 6.
- accelX=+100, accelY=0, map_value=0, ack 1 cycle after req -> map_x=2, map_y=1 queried; x_out=2, y_out=1; move_done pulses; no Y request.
- accelX=+100, accelY=-100, map returns WALL_CODE for (2,1) and 0 for (1,0) -> blocked[0] pulse; x_out=1, y_out=0.
- x_out=0, accelX=-200; then accelX=+10 (inside DEADZONE) -> no map_req for X either tick; x_out stays 0.
- Hold map_ack low 20 cycles while a second tick arrives -> map_req and address stable, tick_overrun=1. Assert reset mid-wait -> map_req=0 and x_out=X_START immediately.
- MAP_TIMEOUT_EN with TIMEOUT_CYCLES=64, map_ack never asserted -> after 64 cycles blocked[0] pulses, map_timeout=1, FSM reaches DONE.
